// File: rtl/video_mono_colorizer_pkg.sv
// Shared mode numbering and tint table for the mono video paths.
// The RGB-to-mono path imports the same constants so both directions agree
// on which monitor colour a given gfx_mode stands for.
package video_mono_pkg;

    localparam logic [2:0] MODE_COLOR   = 3'd0;
    localparam logic [2:0] MODE_GREEN   = 3'd1;
    localparam logic [2:0] MODE_AMBER   = 3'd2;
    localparam logic [2:0] MODE_BW      = 3'd3;
    localparam logic [2:0] MODE_RED     = 3'd4;
    localparam logic [2:0] MODE_BLUE    = 3'd5;
    localparam logic [2:0] MODE_FUCHSIA = 3'd6;
    localparam logic [2:0] MODE_PURPLE  = 3'd7;

    // Per-channel gains applied to the luma value (FF means full scale).
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } tint_t;

    // Crossfade controller state, also exported for debug observation.
    typedef enum logic {
        FADE_IDLE   = 1'b0,
        FADE_ACTIVE = 1'b1
    } fade_state_e;

    // Map a gfx_mode value to its tint gains.
    function automatic tint_t tint_lookup(input logic [2:0] mode);
        tint_t t;
        case (mode)
            MODE_COLOR:   t = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            MODE_GREEN:   t = '{r: 8'h00, g: 8'hFF, b: 8'h04};
            MODE_AMBER:   t = '{r: 8'hFF, g: 8'h80, b: 8'h04};
            MODE_BW:      t = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            MODE_RED:     t = '{r: 8'hFF, g: 8'h00, b: 8'h04};
            MODE_BLUE:    t = '{r: 8'h00, g: 8'h80, b: 8'hFF};
            MODE_FUCHSIA: t = '{r: 8'hFF, g: 8'h00, b: 8'h80};
            MODE_PURPLE:  t = '{r: 8'h80, g: 8'h00, b: 8'hFF};
            default:      t = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/video_gain_stepper.sv
// One channel's gain register and its fade target.
// The gain walks toward the target by at most STEP per enabled step and
// lands exactly on it; it can also be snapped to a new value in one clock.
module video_gain_stepper #(
    parameter int STEP = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,          // loads gain and target from i_target
    input  logic       i_load,           // snap gain and target to i_target
    input  logic       i_retarget,       // replace the target, keep the gain
    input  logic [7:0] i_target,
    input  logic       i_step_en,        // move one step toward the target
    output logic [7:0] o_gain,
    output logic       o_at_target_next  // gain after this clock equals the target
);

    localparam logic [7:0] STEP8 = STEP[7:0];

    logic [7:0] r_gain;
    logic [7:0] r_target;

    logic       w_up;
    logic [7:0] w_diff;
    logic [7:0] w_delta;
    logic [7:0] w_stepped;
    logic [7:0] w_gain_next;

    // Distance to the target, clipped to STEP; the clip never exceeds the
    // distance so the add/subtract below cannot wrap or overshoot.
    always_comb begin
        w_up        = (r_target > r_gain);
        w_diff      = w_up ? (r_target - r_gain) : (r_gain - r_target);
        w_delta     = (w_diff < STEP8) ? w_diff : STEP8;
        w_stepped   = w_up ? (r_gain + w_delta) : (r_gain - w_delta);
        w_gain_next = i_step_en ? w_stepped : r_gain;
    end

    // Gain and target registers; a retarget and a step may share a clock,
    // in which case the step still heads toward the old target.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gain   <= i_target;
            r_target <= i_target;
        end else if (i_load) begin
            r_gain   <= i_target;
            r_target <= i_target;
        end else begin
            r_gain <= w_gain_next;
            if (i_retarget) begin
                r_target <= i_target;
            end
        end
    end

    assign o_gain           = r_gain;
    assign o_at_target_next = (w_gain_next == r_target);

endmodule

// File: rtl/video_mono_colorizer.sv
// Tints an 8-bit mono luma stream into RGB using the gfx_mode tint table.
// Tint changes either snap (FADE_EN=0) or crossfade one step per vsync rise.
// Handshake: there is no valid/ready; a pixel is accepted on each rising
// edge of ce_pix and its result appears after the following rising edge.
module video_mono_colorizer
    import video_mono_pkg::*;
#(
    parameter bit         FADE_EN = 1'b1,
    parameter int         STEP    = 16,
    parameter logic [7:0] GLOW    = 8'h08
) (
    input  logic        clk_vid,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        vsync,
    input  logic [2:0]  gfx_mode,
    input  logic [7:0]  luma,
    output logic [7:0]  R_OUT,
    output logic [7:0]  G_OUT,
    output logic [7:0]  B_OUT,
    output logic        busy,
    output fade_state_e o_dbg_state
);

    // Scale luma by (gain+1)/256; channels with a strong gain never drop
    // below the phosphor glow level.
    function automatic logic [7:0] scale_ch(input logic [7:0] l, input logic [7:0] g);
        logic [7:0] ch;
        ch = 8'((16'(l) * (16'(g) + 16'd1)) >> 8);
        if (g[7] && (ch < GLOW)) begin
            ch = GLOW;
        end
        return ch;
    endfunction

    logic        r_ce_d;
    logic        r_vs_d;
    logic [2:0]  r_mode_q;
    fade_state_e r_state;
    logic        r_busy;
    logic [7:0]  r_s1_luma;
    tint_t       r_s1_gain;
    logic [7:0]  r_out_r;
    logic [7:0]  r_out_g;
    logic [7:0]  r_out_b;

    logic        w_ce_rise;
    logic        w_vs_rise;
    logic        w_mode_chg;
    logic        w_load;
    logic        w_retarget;
    logic        w_step_en;
    tint_t       w_tint_new;
    tint_t       w_gain;
    logic [7:0]  w_gain_r;
    logic [7:0]  w_gain_g;
    logic [7:0]  w_gain_b;
    logic [2:0]  w_at_next;

    assign w_ce_rise  = ce_pix & ~r_ce_d;
    assign w_vs_rise  = vsync & ~r_vs_d;
    assign w_mode_chg = (gfx_mode != r_mode_q);
    assign w_tint_new = tint_lookup(gfx_mode);
    assign w_load     = (FADE_EN == 1'b0) && w_mode_chg;
    assign w_retarget = (FADE_EN == 1'b1) && w_mode_chg;
    assign w_step_en  = (r_state == FADE_ACTIVE) && w_vs_rise;
    assign w_gain     = '{r: w_gain_r, g: w_gain_g, b: w_gain_b};

    // Edge-detect history and mode tracking, sampled every clock.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_ce_d   <= 1'b0;
            r_vs_d   <= 1'b0;
            r_mode_q <= gfx_mode;
        end else begin
            r_ce_d   <= ce_pix;
            r_vs_d   <= vsync;
            r_mode_q <= gfx_mode;
        end
    end

    video_gain_stepper #(.STEP(STEP)) u_step_r (
        .i_clk            (clk_vid),
        .i_reset          (reset),
        .i_load           (w_load),
        .i_retarget       (w_retarget),
        .i_target         (w_tint_new.r),
        .i_step_en        (w_step_en),
        .o_gain           (w_gain_r),
        .o_at_target_next (w_at_next[0])
    );

    video_gain_stepper #(.STEP(STEP)) u_step_g (
        .i_clk            (clk_vid),
        .i_reset          (reset),
        .i_load           (w_load),
        .i_retarget       (w_retarget),
        .i_target         (w_tint_new.g),
        .i_step_en        (w_step_en),
        .o_gain           (w_gain_g),
        .o_at_target_next (w_at_next[1])
    );

    video_gain_stepper #(.STEP(STEP)) u_step_b (
        .i_clk            (clk_vid),
        .i_reset          (reset),
        .i_load           (w_load),
        .i_retarget       (w_retarget),
        .i_target         (w_tint_new.b),
        .i_step_en        (w_step_en),
        .o_gain           (w_gain_b),
        .o_at_target_next (w_at_next[2])
    );

    // Fade controller: a mode change starts or retargets a fade; the fade
    // ends on the clock its last step lands unless a new mode arrives then.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_state <= FADE_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                FADE_IDLE: begin
                    if (w_retarget) begin
                        r_state <= FADE_ACTIVE;
                        r_busy  <= 1'b1;
                    end
                end
                FADE_ACTIVE: begin
                    if (!w_mode_chg && (&w_at_next)) begin
                        r_state <= FADE_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FADE_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage pixel pipeline: S1 captures luma with the gains in force
    // before any same-clock fade step, S2 scales into the output registers.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_s1_luma <= 8'h00;
            r_s1_gain <= '0;
            r_out_r   <= 8'h00;
            r_out_g   <= 8'h00;
            r_out_b   <= 8'h00;
        end else if (w_ce_rise) begin
            r_s1_luma <= luma;
            r_s1_gain <= w_gain;
            r_out_r   <= scale_ch(r_s1_luma, r_s1_gain.r);
            r_out_g   <= scale_ch(r_s1_luma, r_s1_gain.g);
            r_out_b   <= scale_ch(r_s1_luma, r_s1_gain.b);
        end
    end

    assign R_OUT       = r_out_r;
    assign G_OUT       = r_out_g;
    assign B_OUT       = r_out_b;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule
